decoder_rr_arbiter: RTL and testbench



---
 rtl/decoder_rr_arbiter_pkg.sv | 13 +
 rtl/decoder_rr_arbiter_decoder_4x16_en.sv | 15 +
 rtl/decoder_rr_arbiter.sv | 98 +++++++++
 tb/tb_decoder_rr_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/decoder_rr_arbiter_pkg.sv
// Shared types and sizes for the 16-way round-robin arbiter and its grant decoder.
package decoder_rr_arbiter_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/decoder_rr_arbiter_decoder_4x16_en.sv
// Enabled 4-to-16 decoder turning the registered winner index into a one-hot grant.
module decoder_4x16_en
  import decoder_rr_arbiter_pkg::*;
(
  input  logic [IDX_W-1:0] gnt_idx,
  input  logic             gnt_valid,
  output logic [N_REQ-1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (gnt_valid) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter for 16 requesters with request/release handshake,
// one-cycle turnaround gap between grants and an optional hold timeout.
module decoder_rr_arbiter
  import decoder_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             preempt
);

  localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  arb_state_t       state;
  logic [IDX_W-1:0] ptr;
  logic [CNT_W-1:0] hold_cnt;
  logic [IDX_W-1:0] winner;
  logic             others_pending;
  logic             timeout;

  // Rotate so ptr lands on bit 0, take the lowest set bit, then undo the rotation.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] p);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   off;
    dbl = {r, r} >> p;
    rot = dbl[N_REQ-1:0];
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    return p + off;
  endfunction

  assign winner         = rr_pick(req, ptr);
  assign others_pending = |(req & ~gnt);
  assign timeout        = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      preempt   <= 1'b0;
      ptr       <= '0;
      hold_cnt  <= '0;
    end else begin
      preempt <= 1'b0;
      case (state)
        IDLE, GAP: begin
          if (en && (|req)) begin
            state     <= GRANT;
            gnt_idx   <= winner;
            gnt_valid <= 1'b1;
            hold_cnt  <= '0;
          end else begin
            state     <= IDLE;
            gnt_valid <= 1'b0;
          end
        end
        GRANT: begin
          if (hold_cnt != HOLD_SAT) hold_cnt <= hold_cnt + 1'b1;
          // Release takes precedence, so a holder dropping on its last cycle is not flagged as preempted.
          if (!req[gnt_idx]) begin
            state     <= GAP;
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx + IDX_W'(1);
          end else if (timeout && others_pending) begin
            state     <= GAP;
            gnt_valid <= 1'b0;
            ptr       <= gnt_idx + IDX_W'(1);
            preempt   <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

  decoder_4x16_en u_decoder (
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .gnt      (gnt)
  );

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Self-checking bench: cycle model of the arbitration rules plus directed vectors with literal expectations.
module tb_decoder_rr_arbiter;

  localparam int MH = 4;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] req;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_valid;
  logic        preempt;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: who holds the resource, how many grant cycles they have used, and where the search starts.
  bit m_ready   = 0;
  bit m_holding = 0;
  bit m_gap     = 0;
  bit m_pre     = 0;
  int m_idx     = 0;
  int m_ptr     = 0;
  int m_used    = 0;

  decoder_rr_arbiter #(.MAX_HOLD(MH), .CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .req      (req),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .preempt  (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic r, input logic e, input logic [15:0] q);
    rst = r;
    en  = e;
    req = q;
  endtask

  // Search from m_ptr upward, wrapping, for the first requester.
  function automatic int first_from_ptr(input logic [15:0] q, input int p);
    for (int k = 0; k < 16; k++) begin
      if (q[(p + k) % 16]) return (p + k) % 16;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ready = 1; m_holding = 0; m_gap = 0; m_pre = 0;
      m_idx = 0; m_ptr = 0; m_used = 0;
    end else if (m_ready) begin
      m_pre = 0;
      if (m_holding) begin
        m_used++;
        if (!req[m_idx]) begin
          m_holding = 0; m_gap = 1; m_ptr = (m_idx + 1) % 16;
        end else if (MH != 0 && m_used >= MH && (req & ~(16'h1 << m_idx)) != 16'h0) begin
          m_holding = 0; m_gap = 1; m_ptr = (m_idx + 1) % 16; m_pre = 1;
        end
      end else begin
        m_gap = 0;
        if (en && req != 16'h0) begin
          m_holding = 1; m_idx = first_from_ptr(req, m_ptr); m_used = 0;
        end
      end
    end
    #1;
    if (m_ready) begin
      check_output("gnt", 32'(gnt), m_holding ? 32'(16'h1 << m_idx) : 32'h0);
      check_output("gnt_idx", 32'(gnt_idx), 32'(m_idx));
      check_output("gnt_valid", 32'(gnt_valid), 32'(m_holding));
      check_output("preempt", 32'(preempt), 32'(m_pre));
    end
  end

  initial begin
    apply_stimulus(1'b1, 1'b0, 16'h0000);
    tick(2);
    check_output("reset gnt", 32'(gnt), 32'h0);
    check_output("reset gnt_idx", 32'(gnt_idx), 32'h0);
    check_output("reset gnt_valid", 32'(gnt_valid), 32'h0);
    check_output("reset preempt", 32'(preempt), 32'h0);

    // Single request, then release into one gap cycle and idle.
    apply_stimulus(1'b0, 1'b1, 16'h0001);
    tick(1);
    check_output("t1 gnt", 32'(gnt), 32'h0001);
    check_output("t1 gnt_valid", 32'(gnt_valid), 32'h1);
    apply_stimulus(1'b0, 1'b1, 16'h0000);
    tick(1);
    check_output("t1 gap gnt", 32'(gnt), 32'h0);
    tick(1);
    check_output("t1 idle valid", 32'(gnt_valid), 32'h0);

    // All requesting: ptr is 1 after releasing 0, each holder gets MH cycles then is preempted.
    apply_stimulus(1'b0, 1'b1, 16'hFFFF);
    tick(1);
    check_output("t2 first idx", 32'(gnt_idx), 32'h1);
    tick(MH - 1);
    check_output("t2 still held", 32'(gnt), 32'h0002);
    tick(1);
    check_output("t2 gap valid", 32'(gnt_valid), 32'h0);
    check_output("t2 preempt", 32'(preempt), 32'h1);
    tick(1);
    check_output("t2 next idx", 32'(gnt_idx), 32'h2);
    check_output("t2 preempt drop", 32'(preempt), 32'h0);
    tick(12 * (MH + 1));
    check_output("t2 idx 14", 32'(gnt_idx), 32'd14);

    // Requester 14 releases: 15 wins next, then wrap to 0 after timeout.
    apply_stimulus(1'b0, 1'b1, 16'h8001);
    tick(1);
    check_output("t3 release no preempt", 32'(preempt), 32'h0);
    tick(1);
    check_output("t3 gnt 15", 32'(gnt), 32'h8000);
    tick(MH);
    check_output("t3 timeout preempt", 32'(preempt), 32'h1);
    tick(1);
    check_output("t3 wrap to 0", 32'(gnt), 32'h0001);
    apply_stimulus(1'b0, 1'b1, 16'h0000);
    tick(2);

    // Sole requester never times out.
    apply_stimulus(1'b0, 1'b1, 16'h0020);
    tick(41);
    check_output("t4 gnt 5", 32'(gnt), 32'h0020);
    check_output("t4 no preempt", 32'(preempt), 32'h0);
    apply_stimulus(1'b0, 1'b1, 16'h0000);
    tick(2);

    // Enable gating: blocks new grants only.
    apply_stimulus(1'b0, 1'b0, 16'h0010);
    tick(3);
    check_output("t5 blocked", 32'(gnt), 32'h0);
    apply_stimulus(1'b0, 1'b1, 16'h0010);
    tick(1);
    check_output("t5 granted", 32'(gnt), 32'h0010);
    apply_stimulus(1'b0, 1'b0, 16'h0010);
    tick(10);
    check_output("t5 persists", 32'(gnt), 32'h0010);
    apply_stimulus(1'b0, 1'b0, 16'h0000);
    tick(2);
    check_output("t5 idle", 32'(gnt_valid), 32'h0);

    // Reset mid-grant clears the pointer back to 0.
    apply_stimulus(1'b0, 1'b1, 16'h0100);
    tick(1);
    check_output("t6 gnt 8", 32'(gnt), 32'h0100);
    apply_stimulus(1'b1, 1'b1, 16'h0100);
    tick(1);
    check_output("t6 reset gnt", 32'(gnt), 32'h0);
    apply_stimulus(1'b0, 1'b1, 16'h0101);
    tick(1);
    check_output("t6 req0 wins", 32'(gnt), 32'h0001);

    // Release on the timeout cycle counts as release.
    tick(MH - 1);
    apply_stimulus(1'b0, 1'b1, 16'h0100);
    tick(1);
    check_output("t7 release wins", 32'(preempt), 32'h0);
    check_output("t7 gap", 32'(gnt_valid), 32'h0);
    tick(1);
    check_output("t7 next 8", 32'(gnt_idx), 32'h8);
    apply_stimulus(1'b0, 1'b1, 16'h0000);
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
